// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_AW = 9;
  localparam int unsigned DEF_DW = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes plus memory pins for mem_arbiter.
// slave = arbiter side, master = requesters/memory side.
interface mem_arbiter_if #(
  parameter int unsigned AW = mem_arb_pkg::DEF_AW,
  parameter int unsigned DW = mem_arb_pkg::DEF_DW
) ();

  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_ack;

  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_ack;

  logic [DW-1:0] rdata;
  logic          busy;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_ack, p1_ack, rdata, busy,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_ack, p1_ack, rdata, busy,
    input  mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between two requesters.
// MEM_ARB_RR_EN: round-robin on ties using the last-grant pointer; else port 0 wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
`ifdef MEM_ARB_RR_EN
  input  logic ptr_i,
`endif
  output logic any_o,
  output logic win_o
);

  always_comb begin
    any_o = req0_i | req1_i;
`ifdef MEM_ARB_RR_EN
    if (req0_i && req1_i) begin
      win_o = (ptr_i == PORT_CPU) ? PORT_AUX : PORT_CPU;
    end else begin
      win_o = req1_i ? PORT_AUX : PORT_CPU;
    end
`else
    win_o = (!req0_i && req1_i) ? PORT_AUX : PORT_CPU;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer for the unified memory: IDLE -> ACCESS -> ACK.
// MEM_ARB_RR_EN selects round-robin tie-breaking; undefined gives fixed priority to port 0.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
) (
  input  logic          clk,
  input  logic          clr_n,
  mem_arbiter_if.slave  bus
);

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          any_req;
  logic          win;

`ifdef MEM_ARB_RR_EN
  logic          ptr_q, ptr_d;
`endif

  mem_arb_pick u_pick (
    .req0_i (bus.p0_req),
    .req1_i (bus.p1_req),
`ifdef MEM_ARB_RR_EN
    .ptr_i  (ptr_q),
`endif
    .any_o  (any_req),
    .win_o  (win)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    rdata_d     = rdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
`ifdef MEM_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d     = win;
          mem_addr_d  = (win == PORT_AUX) ? bus.p1_addr  : bus.p0_addr;
          mem_wdata_d = (win == PORT_AUX) ? bus.p1_wdata : bus.p0_wdata;
          mem_we_d    = (win == PORT_AUX) ? bus.p1_we    : bus.p0_we;
`ifdef MEM_ARB_RR_EN
          ptr_d       = win;
`endif
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        // mem_we_q still reflects this access here, so it distinguishes read from write
        if (!mem_we_q) rdata_d = bus.mem_rdata;
        mem_we_d = 1'b0;
        ack0_d   = (grant_q == PORT_CPU);
        ack1_d   = (grant_q == PORT_AUX);
        state_d  = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      grant_q     <= PORT_CPU;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rdata_q     <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      ptr_q       <= PORT_AUX;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rdata_q     <= rdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
`ifdef MEM_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.rdata     = rdata_q;
  assign bus.p0_ack    = ack0_q;
  assign bus.p1_ack    = ack1_q;
  assign bus.busy      = (state_q == ACCESS) || (state_q == ACK);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a 512x32 behavioural memory.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        clr_n;
  logic        pl_we;
  logic [8:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] mem [512];
  exp_t        exp_q [$];
  int          tests;
  int          fails;
  int          cyc;
  int          we_run;
  int          ack0_cnt;
  int          ack1_cnt;

  mem_arbiter_if #(.AW(9), .DW(32)) bus ();

  mem_arbiter #(.AW(9), .DW(32)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  assign bus.mem_rdata = mem[bus.mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every ack and tracks write-enable pulse width.
  always @(negedge clk) begin
    if (!clr_n) begin
      we_run = 0;
    end else begin
      if (bus.mem_we) begin
        we_run++;
      end else if (we_run != 0) begin
        check("mem_we_width", we_run, 1);
        we_run = 0;
      end
      if (bus.p0_ack || bus.p1_ack) begin
        if (bus.p0_ack) ack0_cnt++;
        if (bus.p1_ack) ack1_cnt++;
        check("ack_onehot", {31'b0, bus.p0_ack & bus.p1_ack}, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {30'b0, bus.p1_ack, bus.p0_ack}, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ack_port", {31'b0, bus.p1_ack}, {31'b0, e.port});
          check("rdata", bus.rdata, e.rdata);
        end
      end
    end
  end

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    @(posedge clk); #1;
    pl_we   = 1'b0;
  endtask

  task automatic set_port(input logic port, input logic req, input logic we,
                          input logic [8:0] a, input logic [31:0] d);
    if (port == PORT_AUX) begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
    end else begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
    end
  endtask

  task automatic wait_ack(input logic port, output int n);
    logic got;
    got = 1'b0;
    n = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      got = (port == PORT_AUX) ? bus.p1_ack : bus.p0_ack;
    end
  endtask

  // Single access from an idle arbiter; ack expected at the 3rd falling edge (req cycle + 2).
  task automatic do_access(input logic port, input logic we, input logic [8:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rdata);
    int n;
    @(posedge clk); #1;
    exp_q.push_back('{port: port, rdata: exp_rdata});
    set_port(port, 1'b1, we, a, d);
    wait_ack(port, n);
    check("ack_latency", n, 3);
    @(posedge clk); #1;
    set_port(port, 1'b0, 1'b0, a, d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_addr"},  {23'b0, bus.mem_addr}, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check({tag, "_mem_we"},    {31'b0, bus.mem_we}, 0);
    check({tag, "_acks"},      {30'b0, bus.p1_ack, bus.p0_ack}, 0);
    check({tag, "_rdata"},     bus.rdata, 0);
    check({tag, "_busy"},      {31'b0, bus.busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0, t1;
    tests = 0; fails = 0; cyc = 0; we_run = 0; ack0_cnt = 0; ack1_cnt = 0;
    clr_n = 1'b0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    set_port(PORT_CPU, 1'b0, 1'b0, '0, '0);
    set_port(PORT_AUX, 1'b0, 1'b0, '0, '0);

    preload(9'h1FF, 32'h1234_5678);
    preload(9'h020, 32'hA5A5_0000);
    preload(9'h021, 32'h5A5A_1111);
    preload(9'h022, 32'h0000_2222);
    preload(9'h023, 32'h0000_3333);
    preload(9'h030, 32'h1111_2222);
    preload(9'h040, 32'h0BAD_F00D);
    preload(9'h041, 32'h0000_0041);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    clr_n = 1'b1;

    // Port 0 write then read back; write leaves rdata at its reset value.
    do_access(PORT_CPU, 1'b1, 9'h010, 32'hDEAD_BEEF, 32'h0);
    check("mem_after_write", mem[9'h010], 32'hDEAD_BEEF);
    do_access(PORT_CPU, 1'b0, 9'h010, 32'h0, 32'hDEAD_BEEF);

    // Port 1 read at the top address.
    do_access(PORT_AUX, 1'b0, 9'h1FF, 32'h0, 32'h1234_5678);

    // Both ports requesting for 24 cycles.
    @(posedge clk); #1;
    ack0_cnt = 0; ack1_cnt = 0;
    for (int unsigned i = 0; i < 8; i++) begin
`ifdef MEM_ARB_RR_EN
      if (i % 2 == 0) exp_q.push_back('{port: PORT_CPU, rdata: 32'hA5A5_0000});
      else            exp_q.push_back('{port: PORT_AUX, rdata: 32'h5A5A_1111});
`else
      exp_q.push_back('{port: PORT_CPU, rdata: 32'hA5A5_0000});
`endif
    end
    set_port(PORT_CPU, 1'b1, 1'b0, 9'h020, '0);
    set_port(PORT_AUX, 1'b1, 1'b0, 9'h021, '0);
    repeat (24) @(posedge clk);
    #1;
    set_port(PORT_CPU, 1'b0, 1'b0, '0, '0);
    set_port(PORT_AUX, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
`ifdef MEM_ARB_RR_EN
    check("contend_p0_acks", ack0_cnt, 4);
    check("contend_p1_acks", ack1_cnt, 4);
`else
    check("contend_p0_acks", ack0_cnt, 8);
    check("contend_p1_acks", ack1_cnt, 0);
`endif
    check("contend_queue_empty", exp_q.size(), 0);

    // Port 1 arrives during port 0's ACCESS cycle.
    @(posedge clk); #1;
    exp_q.push_back('{port: PORT_CPU, rdata: 32'h0000_2222});
    exp_q.push_back('{port: PORT_AUX, rdata: 32'h0000_3333});
    set_port(PORT_CPU, 1'b1, 1'b0, 9'h022, '0);
    @(posedge clk); #1;
    set_port(PORT_AUX, 1'b1, 1'b0, 9'h023, '0);
    wait_ack(PORT_CPU, n);
    check("late_p0_ack_seen", n < 10, 1);
    t0 = cyc;
    @(posedge clk); #1;
    set_port(PORT_CPU, 1'b0, 1'b0, '0, '0);
    wait_ack(PORT_AUX, n);
    check("late_p1_ack_seen", n < 10, 1);
    t1 = cyc;
    check("late_p1_gap", t1 - t0, 3);
    @(posedge clk); #1;
    set_port(PORT_AUX, 1'b0, 1'b0, '0, '0);

    // Reset during a port 0 write's ACCESS cycle, before the committing edge.
    @(posedge clk); #1;
    set_port(PORT_CPU, 1'b1, 1'b1, 9'h030, 32'hCAFE_F00D);
    @(posedge clk); #2;
    check("abort_we_before", {31'b0, bus.mem_we}, 1);
    clr_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    set_port(PORT_CPU, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_mem_unchanged", mem[9'h030], 32'h1111_2222);
    check("abort_queue_empty", exp_q.size(), 0);

    // Reset release with both requests already high.
    set_port(PORT_CPU, 1'b1, 1'b0, 9'h040, '0);
    set_port(PORT_AUX, 1'b1, 1'b0, 9'h041, '0);
    exp_q.push_back('{port: PORT_CPU, rdata: 32'h0BAD_F00D});
    ack1_cnt = 0;
    @(posedge clk); #1;
    clr_n = 1'b1;
    wait_ack(PORT_CPU, n);
    check("release_first_grant_latency", n, 3);
    @(posedge clk); #1;
    set_port(PORT_CPU, 1'b0, 1'b0, '0, '0);
    set_port(PORT_AUX, 1'b0, 1'b0, '0, '0);
    repeat (4) @(posedge clk);
    #1;
    check("release_p1_not_acked", ack1_cnt, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
